// File: rtl/mux_n_1_pkg.sv
// Shared mode encoding for the registered N:1 channel multiplexer.
package mux_n_1_pkg;

  typedef enum logic {
    MODE_SEL = 1'b0,
    MODE_RR  = 1'b1
  } mode_e;

endpackage

// File: rtl/mux_n_1_reg_rr_pick.sv
// Rotated priority search: first set req bit starting at ptr, wrapping mod N. Purely combinational.
module rr_pick #(
  parameter int N    = 8,
  parameter int SELW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic            found,
  output logic [SELW-1:0] idx
);

  localparam logic [SELW:0] N_W = (SELW+1)'(N);

  logic [SELW:0] cand;

  // Walk from the farthest offset back to ptr so the closest requester wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = N-1; k >= 0; k--) begin
      cand = {1'b0, ptr} + (SELW+1)'(k);
      if (cand >= N_W) begin
        cand = cand - N_W;
      end
      if (req[cand[SELW-1:0]]) begin
        found = 1'b1;
        idx   = cand[SELW-1:0];
      end
    end
  end

endmodule

// File: rtl/mux_n_1_reg.sv
// Registered N:1 channel mux with per-channel valid/ready, explicit-select and round-robin modes.
// MUX_N_1_REG_PARITY_EN adds a registered even-parity output aligned with out_data.
module mux_n_1_reg
  import mux_n_1_pkg::*;
#(
  parameter int N    = 8,
  parameter int W    = 8,
  parameter int SELW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N*W-1:0]  in_data,
  input  logic [N-1:0]    in_valid,
  output logic [N-1:0]    in_ready,
  input  logic            mode,
  input  logic [SELW-1:0] sel,
  output logic [W-1:0]    out_data,
  output logic [SELW-1:0] out_chan,
  output logic            out_valid,
  input  logic            out_ready
`ifdef MUX_N_1_REG_PARITY_EN
  ,output logic           out_parity
`endif
);

  localparam logic [SELW:0] N_W = (SELW+1)'(N);

  logic [W-1:0]    out_data_q,  out_data_d;
  logic [SELW-1:0] out_chan_q,  out_chan_d;
  logic            out_valid_q, out_valid_d;
  logic [SELW-1:0] ptr_q,       ptr_d;

  logic            load;
  logic            sel_hit;
  logic            rr_found;
  logic [SELW-1:0] rr_idx;
  logic            grant_vld;
  logic [SELW-1:0] grant_idx;
  logic [W-1:0]    grant_dat;

  rr_pick #(
    .N    (N),
    .SELW (SELW)
  ) u_rr_pick (
    .req   (in_valid),
    .ptr   (ptr_q),
    .found (rr_found),
    .idx   (rr_idx)
  );

  // Out-of-range select is masked before it can reach the grant.
  always_comb begin
    load      = !out_valid_q || out_ready;
    sel_hit   = ({1'b0, sel} < N_W) && in_valid[sel];
    grant_vld = 1'b0;
    grant_idx = '0;
    if (mode == MODE_RR) begin
      grant_vld = rr_found;
      grant_idx = rr_idx;
    end else begin
      grant_vld = sel_hit;
      grant_idx = sel;
    end
    grant_dat = in_data[grant_idx*W +: W];
  end

  always_comb begin
    in_ready = '0;
    if (load && grant_vld) begin
      in_ready[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (load) begin
      out_valid_d = grant_vld;
      if (grant_vld) begin
        out_data_d = grant_dat;
        out_chan_d = grant_idx;
        if (mode == MODE_RR) begin
          ptr_d = (grant_idx == SELW'(N-1)) ? '0 : grant_idx + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign out_valid = out_valid_q;

`ifdef MUX_N_1_REG_PARITY_EN
  logic parity_q, parity_d;

  always_comb begin
    parity_d = parity_q;
    if (load && grant_vld) begin
      parity_d = ^grant_dat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end

  assign out_parity = parity_q;
`endif

endmodule

// File: tb/tb_mux_n_1_reg.sv
// Directed bench for mux_n_1_reg: N=8 instance with an output scoreboard, N=5 instance for out-of-range select.
module tb_mux_n_1_reg;
  import mux_n_1_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [63:0] in_data;
  logic [7:0]  in_valid, in_ready;
  logic        mode;
  logic [2:0]  sel;
  logic [7:0]  out_data;
  logic [2:0]  out_chan;
  logic        out_valid, out_ready;

  logic [39:0] d5_in_data;
  logic [4:0]  d5_in_valid, d5_in_ready;
  logic        d5_mode;
  logic [2:0]  d5_sel;
  logic [7:0]  d5_out_data;
  logic [2:0]  d5_out_chan;
  logic        d5_out_valid, d5_out_ready;

`ifdef MUX_N_1_REG_PARITY_EN
  logic out_parity, d5_out_parity;
`endif

  mux_n_1_reg #(.N(8), .W(8)) u_dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef MUX_N_1_REG_PARITY_EN
    ,.out_parity(out_parity)
`endif
  );

  mux_n_1_reg #(.N(5), .W(8)) u_dut5 (
    .clk       (clk),
    .rst       (rst),
    .in_data   (d5_in_data),
    .in_valid  (d5_in_valid),
    .in_ready  (d5_in_ready),
    .mode      (d5_mode),
    .sel       (d5_sel),
    .out_data  (d5_out_data),
    .out_chan  (d5_out_chan),
    .out_valid (d5_out_valid),
    .out_ready (d5_out_ready)
`ifdef MUX_N_1_REG_PARITY_EN
    ,.out_parity(d5_out_parity)
`endif
  );

  typedef struct packed {
    logic [2:0] chan;
    logic [7:0] data;
    logic       par;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  // Channel payloads and their hand-computed even parity.
  logic [7:0] ch_dat [8] = '{8'h10, 8'h07, 8'h03, 8'hA5, 8'h14, 8'h15, 8'h16, 8'h17};
  logic       ch_par [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic void push(input int ch);
    exp_t e;
    e.chan = 3'(ch);
    e.data = ch_dat[ch];
    e.par  = ch_par[ch];
    sb_q.push_back(e);
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected: got chan %0d data 0x%0h, expected no word", out_chan, out_data);
      end else begin
        mon_e = sb_q.pop_front();
        check("sb_chan", 32'(out_chan), 32'(mon_e.chan));
        check("sb_data", 32'(out_data), 32'(mon_e.data));
`ifdef MUX_N_1_REG_PARITY_EN
        check("sb_parity", 32'(out_parity), 32'(mon_e.par));
`endif
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    in_valid = '0; mode = MODE_SEL; sel = '0; out_ready = 1'b0;
    d5_in_valid = '0; d5_mode = MODE_SEL; d5_sel = '0; d5_out_ready = 1'b0;
    for (int i = 0; i < 8; i++) in_data[i*8 +: 8] = ch_dat[i];
    for (int i = 0; i < 5; i++) d5_in_data[i*8 +: 8] = 8'h50 + 8'(i);

    // Reset state
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_out_chan", 32'(out_chan), 0);
    check("rst_in_ready", 32'(in_ready), 0);
`ifdef MUX_N_1_REG_PARITY_EN
    check("rst_parity", 32'(out_parity), 0);
`endif
    @(posedge clk); #1 rst = 1'b0;

    // Select mode, back-to-back words including the parity pair 07/03
    out_ready = 1'b1; sel = 3'd3; in_valid = 8'h08;
    @(negedge clk); check("sel3_in_ready", 32'(in_ready), 32'h08); push(3);
    @(posedge clk); #1 sel = 3'd1; in_valid = 8'h02;
    @(negedge clk); check("sel1_in_ready", 32'(in_ready), 32'h02);
    check("sel_out_valid", 32'(out_valid), 1); push(1);
    @(posedge clk); #1 sel = 3'd2; in_valid = 8'h04;
    @(negedge clk); check("sel2_in_ready", 32'(in_ready), 32'h04); push(2);
    @(posedge clk); #1 sel = 3'd4; in_valid = 8'h08;
    @(negedge clk); check("sel_invalid_ch", 32'(in_ready), 0);
    @(posedge clk); #1 in_valid = '0;
    @(negedge clk); check("sel_drained", 32'(out_valid), 0);

    // Round-robin, all channels valid: 0..7 then wrap to 0
    @(posedge clk); #1 mode = MODE_RR; in_valid = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      check("rr_in_ready", 32'(in_ready), 32'h1 << (k % 8));
      if (k > 0) check("rr_no_bubble", 32'(out_valid), 1);
      push(k % 8);
      @(posedge clk); #1;
    end

    // Backpressure on the wrapped ch0 word
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_in_ready", 32'(in_ready), 0);
      check("bp_out_valid", 32'(out_valid), 1);
      check("bp_out_chan", 32'(out_chan), 0);
      check("bp_out_data", 32'(out_data), 32'h10);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk); check("bp_release_in_ready", 32'(in_ready), 32'h02); push(1);
    @(posedge clk); #1 in_valid = '0;
    @(negedge clk);
    @(posedge clk); #1;

    // Park a word from ch3 (ptr -> 4), then reset asynchronously mid-cycle
    out_ready = 1'b0; in_valid = 8'h08;
    @(negedge clk); check("pre_rst_in_ready", 32'(in_ready), 32'h08);
    @(posedge clk); #1 in_valid = '0;
    @(negedge clk);
    check("pre_rst_out_valid", 32'(out_valid), 1);
    check("pre_rst_out_chan", 32'(out_chan), 3);
    #2 rst = 1'b1;
    #1;
    check("async_rst_out_valid", 32'(out_valid), 0);
    check("async_rst_out_data", 32'(out_data), 0);
    check("async_rst_out_chan", 32'(out_chan), 0);
    @(posedge clk); #1 rst = 1'b0; in_valid = 8'h24; out_ready = 1'b1;
    @(negedge clk); check("rst_rr_first_grant", 32'(in_ready), 32'h04); push(2);
    @(posedge clk); #1 in_valid = '0;
    @(negedge clk);

    // N=5: out-of-range select never grants, held word still drains
    @(posedge clk); #1 d5_in_valid = 5'h1F; d5_sel = 3'd2; d5_out_ready = 1'b0;
    @(negedge clk); check("n5_sel2_in_ready", 32'(d5_in_ready), 32'h04);
    @(posedge clk); #1 d5_sel = 3'd6;
    @(negedge clk);
    check("n5_held_valid", 32'(d5_out_valid), 1);
    check("n5_held_chan", 32'(d5_out_chan), 2);
    check("n5_held_data", 32'(d5_out_data), 32'h52);
    check("n5_sel6_in_ready_bp", 32'(d5_in_ready), 0);
    @(posedge clk); #1 d5_out_ready = 1'b1;
    @(negedge clk);
    check("n5_sel6_in_ready", 32'(d5_in_ready), 0);
    check("n5_still_valid", 32'(d5_out_valid), 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("n5_drained", 32'(d5_out_valid), 0);
    check("n5_no_grant", 32'(d5_in_ready), 0);

    @(posedge clk); #1;
    check("sb_empty", 32'(sb_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
